// File: rtl/bk_pkg.sv
// Shared types for the digit-serial Brent-Kung adder: digit width, digit type
// and the two-state operand FSM encoding.
package bk_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bk_state_t;

endpackage

// File: rtl/bk_serial_adder_bk4_cin.sv
// bk4_cin: 4-bit combinational Brent-Kung prefix adder with carry-in.
module bk4_cin
    import bk_pkg::*;
(
    input  digit_t a,
    input  digit_t b,
    input  logic   cin,
    output digit_t sum,
    output logic   cout
);

    digit_t g;
    digit_t p;
    digit_t c;
    logic   g0c;
    logic   g10;
    logic   g32;
    logic   p32;
    logic   g30;
    logic   g20;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        // Carry-in is folded into bit 0's generate so the tree needs no extra level.
        g0c  = g[0] | (p[0] & cin);
        g10  = g[1] | (p[1] & g0c);
        g32  = g[3] | (p[3] & g[2]);
        p32  = p[3] & p[2];
        g30  = g32 | (p32 & g10);
        g20  = g[2] | (p[2] & g10);
        c    = {g20, g10, g0c, cin};
        sum  = p ^ c;
        cout = g30;
    end

endmodule

// File: rtl/bk_serial_adder.sv
// Digit-serial (LSD first) adder with a one-deep output register and
// ready/valid handshakes. Define BK_SERIAL_SUB_EN to add the in_sub port (A-B).
module bk_serial_adder
    import bk_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_a,
    input  logic [3:0]   in_b,
    input  logic         in_last,
`ifdef BK_SERIAL_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   out_sum,
    output logic         out_last,
    output logic         out_cout,
    output logic         out_err,
    output logic         busy
);

    localparam int unsigned         CNT_W    = $clog2(MAX_DIGITS);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(MAX_DIGITS - 1);

    bk_state_t          state_q, state_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    digit_t             out_sum_q, out_sum_d;
    logic               out_last_q, out_last_d;
    logic               out_cout_q, out_cout_d;
    logic               out_err_q, out_err_d;

    logic               xfer;
    logic               trunc;
    logic               last_eff;
    digit_t             b_eff;
    logic               cin;
    digit_t             add_sum;
    logic               add_cout;

`ifdef BK_SERIAL_SUB_EN
    logic               sub_q, sub_d;
    logic               first;
    logic               sub_eff;
`endif

    // ---------------- operand conditioning ----------------
    always_comb begin
`ifdef BK_SERIAL_SUB_EN
        first   = (state_q == IDLE);
        sub_eff = first ? in_sub : sub_q;
        b_eff   = sub_eff ? ~in_b : in_b;
        cin     = first ? sub_eff : carry_q;
`else
        b_eff   = in_b;
        cin     = carry_q;
`endif
    end

    bk4_cin u_adder (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        in_ready = !out_valid_q || out_ready;
        xfer     = in_valid && in_ready;
        trunc    = !in_last && (count_q == LAST_CNT);
        last_eff = in_last || trunc;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = last_eff ? IDLE : RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == RUN);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        carry_d     = carry_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_err_d   = out_err_q;
`ifdef BK_SERIAL_SUB_EN
        sub_d       = sub_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_last_d  = last_eff;
            out_cout_d  = last_eff ? add_cout : 1'b0;
            out_err_d   = trunc;
            if (last_eff) begin
                carry_d = 1'b0;
                count_d = '0;
            end else begin
                carry_d = add_cout;
                count_d = count_q + CNT_W'(1);
            end
`ifdef BK_SERIAL_SUB_EN
            if (first) begin
                sub_d = in_sub;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q     <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
`ifdef BK_SERIAL_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            carry_q     <= carry_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_err_q   <= out_err_d;
`ifdef BK_SERIAL_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;

endmodule
